downsize_fifo_1_clock: RTL and testbench



---
 rtl/downsize_fifo_pkg.sv | 47 ++++
 rtl/simple_dual_port_1_clock_ram.sv | 46 ++++
 rtl/downsize_fifo_1_clock.sv | 163 ++++++++++++++++
 tb/tb_downsize_fifo_1_clock.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/downsize_fifo_pkg.sv
// -----------------------------------------------------------------------------
// downsize_fifo_pkg
//
// Shared helpers for the downsizing FIFO slice. The FIFO parameters belong to
// the module instances, so the derived sizes (ratio, pointer, slice-index and
// count widths) are constant functions that every file evaluates from its own
// parameters.
// -----------------------------------------------------------------------------
package downsize_fifo_pkg;

    // Ceiling log2. clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Number of narrow read slices in one wide write word.
    function automatic int calc_ratio(input int wr_width, input int rd_width);
        return wr_width / rd_width;
    endfunction

    // Memory pointers carry one extra wrap bit above the address.
    function automatic int calc_ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int calc_slice_w(input int ratio);
        return clog2(ratio);
    endfunction

    // Slices held: RAM words plus the output word, each worth RATIO slices.
    function automatic int calc_count_w(input int depth, input int ratio);
        return clog2((depth + 1) * ratio + 1);
    endfunction

endpackage

// File: rtl/simple_dual_port_1_clock_ram.sv
// -----------------------------------------------------------------------------
// simple_dual_port_1_clock_ram
//
// Single-clock simple dual-port RAM: one write port, one synchronous read port
// with a read latency of one cycle and no extra output pipeline. The read data
// register only loads when rden is high, so it holds its word otherwise.
//
// Ports:
//   clk     in   rising-edge clock
//   wren    in   write enable
//   wrAddr  in   write address
//   din     in   write data (C_WIDTH bits)
//   rden    in   read enable; loads dout with mem[rdAddr] on the next edge
//   rdAddr  in   read address
//   dout    out  registered read data (C_WIDTH bits)
// -----------------------------------------------------------------------------
module simple_dual_port_1_clock_ram
    import downsize_fifo_pkg::*;
#(
    parameter int C_WIDTH = 32,
    parameter int C_DEPTH = 512,
    localparam int ADDR_W = clog2(C_DEPTH)
) (
    input  logic               clk,
    input  logic               wren,
    input  logic [ADDR_W-1:0]  wrAddr,
    input  logic [C_WIDTH-1:0] din,
    input  logic               rden,
    input  logic [ADDR_W-1:0]  rdAddr,
    output logic [C_WIDTH-1:0] dout
);

    logic [C_WIDTH-1:0] mem [C_DEPTH];

    // NOTE: the array and its read register have no reset so they map onto
    // block RAM; the FIFO never presents a word it has not written.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[wrAddr] <= din;
        end
        if (rden) begin
            dout <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/downsize_fifo_1_clock.sv
// -----------------------------------------------------------------------------
// downsize_fifo_1_clock
//
// Single-clock FIFO that accepts C_WR_WIDTH-bit words and delivers them as
// C_RD_WIDTH-bit slices, slice 0 (the LSBs) first. The read side is
// first-word-fall-through: the RAM read register acts as the output word
// register and is prefetched whenever it is empty or its last slice is being
// popped, giving one slice per clock with no bubble between words.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   write request
//   din        in   write word (C_WR_WIDTH bits)
//   full       out  RAM holds C_WR_DEPTH words; writes are ignored
//   rd_en      in   pop one slice
//   dout       out  current slice (C_RD_WIDTH bits), zero while empty
//   empty      out  no slice available on dout
//   count      out  slices held in RAM plus output word
//   overflow   out  sticky: write attempted while full      (optional)
//   underflow  out  sticky: read attempted while empty      (optional)
//
// Build option: define DOWNSIZE_FIFO_ERR_FLAGS_EN to add overflow/underflow.
// -----------------------------------------------------------------------------
module downsize_fifo_1_clock
    import downsize_fifo_pkg::*;
#(
    parameter int C_WR_WIDTH = 32,
    parameter int C_RD_WIDTH = 16,
    parameter int C_WR_DEPTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [C_WR_WIDTH-1:0] din,
    output logic                  full,
    input  logic                  rd_en,
    output logic [C_RD_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [calc_count_w(C_WR_DEPTH, calc_ratio(C_WR_WIDTH, C_RD_WIDTH))-1:0] count
`ifdef DOWNSIZE_FIFO_ERR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`else
    // Error flag ports are not present in this build.
`endif
);

    localparam int RATIO   = calc_ratio(C_WR_WIDTH, C_RD_WIDTH);
    localparam int PTR_W   = calc_ptr_w(C_WR_DEPTH);
    localparam int ADDR_W  = PTR_W - 1;
    localparam int SLICE_W = calc_slice_w(RATIO);
    localparam int CNT_W   = calc_count_w(C_WR_DEPTH, RATIO);

    generate
        if ((C_WR_WIDTH % C_RD_WIDTH) != 0 || RATIO < 2 || !is_pow2(RATIO)) begin : g_bad_ratio
            $error("C_WR_WIDTH/C_RD_WIDTH must be an integer power of 2 >= 2");
        end
        if (C_WR_DEPTH < 2 || !is_pow2(C_WR_DEPTH)) begin : g_bad_depth
            $error("C_WR_DEPTH must be a power of 2 >= 2");
        end
    endgenerate

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   mem_rd_ptr;
    logic [SLICE_W-1:0] slice_idx;
    logic               out_valid;
    logic [C_WR_WIDTH-1:0] word_q;

    logic wr_accept;
    logic mem_not_empty;
    logic pop;
    logic pop_last;
    logic fetch;

    // Full compares the wrap-bit pointers, so a word in the output register
    // does not count against RAM capacity.
    assign full          = (wr_ptr - mem_rd_ptr) == PTR_W'(C_WR_DEPTH);
    assign mem_not_empty = (wr_ptr != mem_rd_ptr);
    assign wr_accept     = wr_en && !full;
    assign pop           = rd_en && out_valid;
    assign pop_last      = pop && (slice_idx == SLICE_W'(RATIO - 1));
    assign fetch         = mem_not_empty && (!out_valid || pop_last);
    assign empty         = !out_valid;

    simple_dual_port_1_clock_ram #(
        .C_WIDTH (C_WR_WIDTH),
        .C_DEPTH (C_WR_DEPTH)
    ) u_ram (
        .clk    (clk),
        .wren   (wr_accept),
        .wrAddr (wr_ptr[ADDR_W-1:0]),
        .din    (din),
        .rden   (fetch),
        .rdAddr (mem_rd_ptr[ADDR_W-1:0]),
        .dout   (word_q)
    );

    // The RAM read register is the output word register. It has no reset, so
    // dout is forced to zero whenever it does not hold a valid word; that also
    // keeps stale pre-reset contents from ever reaching dout.
    logic [RATIO-1:0][C_RD_WIDTH-1:0] word_slices;
    assign word_slices = word_q;
    assign dout        = out_valid ? word_slices[slice_idx] : '0;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            mem_rd_ptr <= '0;
            slice_idx  <= '0;
            out_valid  <= 1'b0;
            count      <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fetch) begin
                mem_rd_ptr <= mem_rd_ptr + PTR_W'(1);
            end

            // A fetched word always starts at slice 0; the last pop of a word
            // wraps slice_idx back to 0 on its own since RATIO is a power of 2.
            if (fetch) begin
                out_valid <= 1'b1;
                slice_idx <= '0;
            end else if (pop) begin
                slice_idx <= slice_idx + SLICE_W'(1);
                if (pop_last) begin
                    out_valid <= 1'b0;
                end
            end

            unique case ({wr_accept, pop})
                2'b10:   count <= count + CNT_W'(RATIO);
                2'b01:   count <= count - CNT_W'(1);
                2'b11:   count <= count + CNT_W'(RATIO - 1);
                default: count <= count;
            endcase
        end
    end

`ifdef DOWNSIZE_FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (rd_en && !out_valid) begin
                underflow <= 1'b1;
            end
        end
    end
`else
    // Illegal requests are silently ignored; no error state is kept.
`endif

endmodule

// File: tb/tb_downsize_fifo_1_clock.sv
// -----------------------------------------------------------------------------
// tb_downsize_fifo_1_clock
//
// Directed bench for downsize_fifo_1_clock with C_WR_WIDTH=32, C_RD_WIDTH=16,
// C_WR_DEPTH=4. Inputs change just after the falling edge and outputs are
// sampled at the falling edge, half a period away from the active edge.
// -----------------------------------------------------------------------------
module tb_downsize_fifo_1_clock;

    localparam int WR_W  = 32;
    localparam int RD_W  = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic            clk;
    logic            rst_n;
    logic            wr_en;
    logic [WR_W-1:0] din;
    logic            full;
    logic            rd_en;
    logic [RD_W-1:0] dout;
    logic            empty;
    logic [CNT_W-1:0] count;
`ifdef DOWNSIZE_FIFO_ERR_FLAGS_EN
    logic            overflow;
    logic            underflow;
`endif

    int checks;
    int errors;

    downsize_fifo_1_clock #(
        .C_WR_WIDTH (WR_W),
        .C_RD_WIDTH (RD_W),
        .C_WR_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .din       (din),
        .full      (full),
        .rd_en     (rd_en),
        .dout      (dout),
        .empty     (empty),
        .count     (count)
`ifdef DOWNSIZE_FIFO_ERR_FLAGS_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: through the rising edge to the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL post_reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL post_reset_full: got %b want 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL post_reset_count: got %0d want 0", count); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL post_reset_dout: got %h want 0000", dout); end
    endtask

    task automatic test_single_word();
        din   = 32'hBEEF_1234;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_latency_empty: got %b want 1", empty); end
        step();
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL single_empty: got %b want 0", empty); end
        checks++; if (dout !== 16'h1234) begin errors++; $display("FAIL single_slice0: got %h want 1234", dout); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL single_count2: got %0d want 2", count); end
        rd_en = 1'b1;
        step();
        checks++; if (dout !== 16'hBEEF) begin errors++; $display("FAIL single_slice1: got %h want beef", dout); end
        checks++; if (count !== 4'd1) begin errors++; $display("FAIL single_count1: got %0d want 1", count); end
        step();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_drained_empty: got %b want 1", empty); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL single_count0: got %0d want 0", count); end
    endtask

    task automatic test_fill();
        for (int k = 0; k < 6; k++) begin
            if (k == 5) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b want 1", full); end
                checks++; if (count !== 4'd10) begin errors++; $display("FAIL fill_count: got %0d want 10", count); end
            end
            din   = {16'(16'hA000 + 2 * k + 1), 16'(16'hA000 + 2 * k)};
            wr_en = 1'b1;
            step();
        end
        wr_en = 1'b0;
        checks++; if (count !== 4'd10) begin errors++; $display("FAIL fill_drop_count: got %0d want 10", count); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_drop_full: got %b want 1", full); end
        rd_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (empty !== 1'b0 || dout !== 16'(16'hA000 + i)) begin
                errors++;
                $display("FAIL fill_drain[%0d]: got empty=%b dout=%h want empty=0 dout=%h",
                         i, empty, dout, 16'(16'hA000 + i));
            end
            step();
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained_empty: got %b want 1", empty); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL fill_drained_count: got %0d want 0", count); end
    endtask

    task automatic test_simultaneous();
        logic [15:0] exp_q [7];
        exp_q = '{16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        wr_en = 1'b1;
        din = 32'h2222_1111; step();
        din = 32'h4444_3333; step();
        din = 32'h6666_5555; step();
        wr_en = 1'b0;
        step();
        checks++; if (count !== 4'd6) begin errors++; $display("FAIL simul_pre_count: got %0d want 6", count); end
        checks++; if (dout !== 16'h1111) begin errors++; $display("FAIL simul_pre_dout: got %h want 1111", dout); end
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 32'h8888_7777;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++; if (count !== 4'd7) begin errors++; $display("FAIL simul_count: got %0d want 7", count); end
        rd_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (empty !== 1'b0 || dout !== exp_q[i]) begin
                errors++;
                $display("FAIL simul_drain[%0d]: got empty=%b dout=%h want empty=0 dout=%h",
                         i, empty, dout, exp_q[i]);
            end
            step();
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL simul_drained_empty: got %b want 1", empty); end
    endtask

    // Word k = {2k+1, 2k}: slices come out as 0,1,2,...,31, one per clock
    // starting two clocks after the first write.
    task automatic test_wrap_throughput();
        rd_en = 1'b1;
        for (int t = 0; t < 36; t++) begin
            if (t >= 2 && t < 34) begin
                checks++;
                if (empty !== 1'b0 || dout !== 16'(t - 2)) begin
                    errors++;
                    $display("FAIL wrap_slice[%0d]: got empty=%b dout=%h want empty=0 dout=%h",
                             t - 2, empty, dout, 16'(t - 2));
                end
            end
            wr_en = (t % 2 == 0) && (t < 32);
            din   = {16'(t + 1), 16'(t)};
            step();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_drained_empty: got %b want 1", empty); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_drained_count: got %0d want 0", count); end
    endtask

    task automatic test_midstream_reset();
        wr_en = 1'b1;
        din = 32'h1111_0000; step();
        din = 32'h3333_2222; step();
        din = 32'h5555_4444; step();
        wr_en = 1'b0;
        step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (count !== 4'd5) begin errors++; $display("FAIL mid_pre_count: got %0d want 5", count); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_rst_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL mid_rst_full: got %b want 0", full); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL mid_rst_dout: got %h want 0000", dout); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_release_empty: got %b want 1", empty); end
        din   = 32'hA5A5_5A5A;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        step();
        checks++; if (dout !== 16'h5A5A || empty !== 1'b0) begin errors++; $display("FAIL mid_new_slice0: got empty=%b dout=%h want empty=0 dout=5a5a", empty, dout); end
        checks++; if (count !== 4'd2) begin errors++; $display("FAIL mid_new_count: got %0d want 2", count); end
        rd_en = 1'b1;
        step();
        checks++; if (dout !== 16'hA5A5) begin errors++; $display("FAIL mid_new_slice1: got %h want a5a5", dout); end
        step();
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_no_stale: got %b want 1", empty); end
    endtask

`ifdef DOWNSIZE_FIFO_ERR_FLAGS_EN
    task automatic test_err_flags();
        do_reset();
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL err_reset: got ovf=%b udf=%b want 0 0", overflow, underflow); end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL err_underflow: got %b want 1", underflow); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL err_no_overflow: got %b want 0", overflow); end
        wr_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din = 32'(k);
            step();
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL err_overflow_early: got %b want 0", overflow); end
        step();
        wr_en = 1'b0;
        step();
        step();
        checks++; if (overflow !== 1'b1 || underflow !== 1'b1) begin errors++; $display("FAIL err_sticky: got ovf=%b udf=%b want 1 1", overflow, underflow); end
        do_reset();
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL err_cleared: got ovf=%b udf=%b want 0 0", overflow, underflow); end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        din    = '0;
        @(negedge clk);
        test_reset();
        test_single_word();
        test_fill();
        test_simultaneous();
        test_wrap_throughput();
        test_midstream_reset();
`ifdef DOWNSIZE_FIFO_ERR_FLAGS_EN
        test_err_flags();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
